// File: rtl/bpf_bufmgr.sv
// Packet-buffer ownership manager: NUM_BUFS buffers circulate in arrival order
// through snooper -> bpfcpu -> forwarder, each side following its own ring pointer.
module bpf_bufmgr #(
  parameter int NUM_BUFS  = 4,
  parameter int IDX_WIDTH = 2,
  parameter int LEN_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 snooper_done,
  input  logic [LEN_WIDTH-1:0] snooper_len,
  output logic                 ready_for_snooper,
  output logic [IDX_WIDTH-1:0] snooper_sel,

  input  logic                 cpu_acc,
  input  logic                 cpu_rej,
  output logic                 ready_for_cpu,
  output logic [IDX_WIDTH-1:0] cpu_sel,
  output logic [LEN_WIDTH-1:0] cpu_len,

  input  logic                 forwarder_done,
  output logic                 ready_for_forwarder,
  output logic [IDX_WIDTH-1:0] fwd_sel,
  output logic [LEN_WIDTH-1:0] fwd_len,

  output logic [IDX_WIDTH:0]   occupancy,
  output logic                 proto_err
);

  typedef enum logic [2:0] {
    BUF_FREE,
    BUF_SNOOP,
    BUF_PENDING,
    BUF_CPU,
    BUF_ACCEPTED,
    BUF_REJECTED,
    BUF_FWD
  } buf_state_e;

  buf_state_e           state_q [NUM_BUFS];
  logic [LEN_WIDTH-1:0] len_q   [NUM_BUFS];
  logic [IDX_WIDTH-1:0] sp_q, cp_q, fp_q;
  logic [IDX_WIDTH:0]   occ_q;
  logic                 err_q;

  // Ring increment must wrap at NUM_BUFS-1, not at the index width.
  function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] p);
    return (p == IDX_WIDTH'(NUM_BUFS - 1)) ? '0 : p + IDX_WIDTH'(1);
  endfunction

  logic snp_own, cpu_own, fwd_own;
  logic snp_grab, snp_fire;
  logic cpu_take, cpu_fire;
  logic fwd_take, fwd_fire, rej_retire, retire;
  logic violation;

  assign snp_own  = (state_q[sp_q] == BUF_SNOOP);
  assign cpu_own  = (state_q[cp_q] == BUF_CPU);
  assign fwd_own  = (state_q[fp_q] == BUF_FWD);

  assign snp_grab = (state_q[sp_q] == BUF_FREE);
  assign snp_fire = snp_own & snooper_done;

  assign cpu_take = (state_q[cp_q] == BUF_PENDING);
  assign cpu_fire = cpu_own & (cpu_acc | cpu_rej);

  // Rejected buffers retire straight from fp, so order behind an active FWD is kept.
  assign fwd_take   = (state_q[fp_q] == BUF_ACCEPTED);
  assign fwd_fire   = fwd_own & forwarder_done;
  assign rej_retire = (state_q[fp_q] == BUF_REJECTED);
  assign retire     = fwd_fire | rej_retire;

  assign violation = (snooper_done & ~snp_own)
                   | ((cpu_acc | cpu_rej) & ~cpu_own)
                   | (cpu_acc & cpu_rej)
                   | (forwarder_done & ~fwd_own);

  // The three pointers always address buffers in disjoint states, so the
  // per-side updates below never target the same entry in one cycle.
  // NOTE: sequential state uses non-blocking (<=) so every update in this block
  // sees the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the length array is reset on purpose; cpu_len/fwd_len must read 0
      // out of reset, so this storage cannot be left as an unreset RAM.
      for (int i = 0; i < NUM_BUFS; i++) begin
        state_q[i] <= BUF_FREE;
        len_q[i]   <= '0;
      end
      sp_q  <= '0;
      cp_q  <= '0;
      fp_q  <= '0;
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (snp_grab) state_q[sp_q] <= BUF_SNOOP;
      if (snp_fire) begin
        state_q[sp_q] <= BUF_PENDING;
        len_q[sp_q]   <= snooper_len;
        sp_q          <= wrap_inc(sp_q);
      end

      if (cpu_take) state_q[cp_q] <= BUF_CPU;
      if (cpu_fire) begin
        state_q[cp_q] <= cpu_rej ? BUF_REJECTED : BUF_ACCEPTED;
        cp_q          <= wrap_inc(cp_q);
      end

      if (fwd_take) state_q[fp_q] <= BUF_FWD;
      if (retire) begin
        state_q[fp_q] <= BUF_FREE;
        fp_q          <= wrap_inc(fp_q);
      end

      // Only FREE->SNOOP allocates and only fp retires, so a delta count suffices.
      occ_q <= occ_q + (IDX_WIDTH+1)'(snp_grab) - (IDX_WIDTH+1)'(retire);

      if (violation) err_q <= 1'b1;
    end
  end

  assign ready_for_snooper   = snp_own;
  assign snooper_sel         = sp_q;
  assign ready_for_cpu       = cpu_own;
  assign cpu_sel             = cp_q;
  assign cpu_len             = len_q[cp_q];
  assign ready_for_forwarder = fwd_own;
  assign fwd_sel             = fp_q;
  assign fwd_len             = len_q[fp_q];
  assign occupancy           = occ_q;
  assign proto_err           = err_q;

endmodule

// File: tb/tb_bpf_bufmgr.sv
// Bench for bpf_bufmgr: directed ownership/latency steps on 4- and 3-buffer
// instances, then randomized traffic scored against packet-order queues.
module tb_bpf_bufmgr;
  localparam int LW = 12;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [LW-1:0] len;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic snooper_done = 1'b0;
  logic [LW-1:0] snooper_len = '0;
  logic cpu_acc = 1'b0;
  logic cpu_rej = 1'b0;
  logic forwarder_done = 1'b0;
  logic use3 = 1'b0;

  logic          d4_rs, d4_rc, d4_rf, d4_err;
  logic [IW-1:0] d4_ss, d4_sc, d4_sf;
  logic [LW-1:0] d4_lc, d4_lf;
  logic [IW:0]   d4_occ;
  logic          d3_rs, d3_rc, d3_rf, d3_err;
  logic [IW-1:0] d3_ss, d3_sc, d3_sf;
  logic [LW-1:0] d3_lc, d3_lf;
  logic [IW:0]   d3_occ;

  logic          r_snp, r_cpu, r_fwd, r_err;
  logic [IW-1:0] s_snp, s_cpu, s_fwd;
  logic [LW-1:0] l_cpu, l_fwd;
  logic [IW:0]   occ;

  int n_cmp = 0;
  int n_err = 0;

  bpf_bufmgr #(.NUM_BUFS(4), .IDX_WIDTH(IW), .LEN_WIDTH(LW)) dut4 (
    .clk(clk), .rst(rst),
    .snooper_done(snooper_done), .snooper_len(snooper_len),
    .ready_for_snooper(d4_rs), .snooper_sel(d4_ss),
    .cpu_acc(cpu_acc), .cpu_rej(cpu_rej),
    .ready_for_cpu(d4_rc), .cpu_sel(d4_sc), .cpu_len(d4_lc),
    .forwarder_done(forwarder_done),
    .ready_for_forwarder(d4_rf), .fwd_sel(d4_sf), .fwd_len(d4_lf),
    .occupancy(d4_occ), .proto_err(d4_err)
  );

  bpf_bufmgr #(.NUM_BUFS(3), .IDX_WIDTH(IW), .LEN_WIDTH(LW)) dut3 (
    .clk(clk), .rst(rst),
    .snooper_done(snooper_done), .snooper_len(snooper_len),
    .ready_for_snooper(d3_rs), .snooper_sel(d3_ss),
    .cpu_acc(cpu_acc), .cpu_rej(cpu_rej),
    .ready_for_cpu(d3_rc), .cpu_sel(d3_sc), .cpu_len(d3_lc),
    .forwarder_done(forwarder_done),
    .ready_for_forwarder(d3_rf), .fwd_sel(d3_sf), .fwd_len(d3_lf),
    .occupancy(d3_occ), .proto_err(d3_err)
  );

  // Both instances see the same stimulus; use3 picks which one is observed.
  assign r_snp = use3 ? d3_rs  : d4_rs;
  assign r_cpu = use3 ? d3_rc  : d4_rc;
  assign r_fwd = use3 ? d3_rf  : d4_rf;
  assign r_err = use3 ? d3_err : d4_err;
  assign s_snp = use3 ? d3_ss  : d4_ss;
  assign s_cpu = use3 ? d3_sc  : d4_sc;
  assign s_fwd = use3 ? d3_sf  : d4_sf;
  assign l_cpu = use3 ? d3_lc  : d4_lc;
  assign l_fwd = use3 ? d3_lf  : d4_lf;
  assign occ   = use3 ? d3_occ : d4_occ;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    snooper_done   = 1'b0;
    cpu_acc        = 1'b0;
    cpu_rej        = 1'b0;
    forwarder_done = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  function automatic logic ready_of(input int which);
    case (which)
      0:       return r_snp;
      1:       return r_cpu;
      default: return r_fwd;
    endcase
  endfunction

  task automatic wait_rdy(input int which, input string tag);
    int n = 0;
    while (!ready_of(which) && n < 200) begin
      step();
      n++;
    end
    check(tag, 32'(ready_of(which)), 1);
  endtask

  task automatic pulse_snoop(input logic [LW-1:0] len);
    snooper_len  = len;
    snooper_done = 1'b1;
    step();
    snooper_done = 1'b0;
  endtask

  task automatic pulse_cpu(input logic acc, input logic rej);
    cpu_acc = acc;
    cpu_rej = rej;
    step();
    cpu_acc = 1'b0;
    cpu_rej = 1'b0;
  endtask

  task automatic pulse_fwd();
    forwarder_done = 1'b1;
    step();
    forwarder_done = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rs"},  32'(r_snp), 0);
    check({tag, "_rc"},  32'(r_cpu), 0);
    check({tag, "_rf"},  32'(r_fwd), 0);
    check({tag, "_ss"},  32'(s_snp), 0);
    check({tag, "_sc"},  32'(s_cpu), 0);
    check({tag, "_sf"},  32'(s_fwd), 0);
    check({tag, "_lc"},  32'(l_cpu), 0);
    check({tag, "_lf"},  32'(l_fwd), 0);
    check({tag, "_occ"}, 32'(occ),   0);
    check({tag, "_err"}, 32'(r_err), 0);
  endtask

  // Reference: packets are tracked purely by arrival order. Snooper indices
  // count modulo nb, the CPU sees snooped packets FIFO, the forwarder sees the
  // accepted subset FIFO; once everything drains only the snooper holds a buffer.
  task automatic random_run(input int nb, input int cycles, input logic b3);
    pkt_t q_cpu[$];
    pkt_t q_fwd[$];
    pkt_t p;
    int   exp_sp = 0;
    int   c = 0;
    use3 = b3;
    do_reset();
    while (c < cycles || ((q_cpu.size() != 0 || q_fwd.size() != 0) && c < cycles + 1000)) begin
      clr();
      if (r_snp) begin
        check("rnd_snp_sel", 32'(s_snp), exp_sp);
        if (c < cycles && $urandom_range(0, 1) == 1) begin
          p.idx = IW'(exp_sp);
          p.len = LW'($urandom_range(0, 4095));
          snooper_len  = p.len;
          snooper_done = 1'b1;
          q_cpu.push_back(p);
          exp_sp = (exp_sp + 1) % nb;
        end
      end
      if (r_cpu) begin
        check("rnd_cpu_has_pkt", 32'(q_cpu.size() != 0), 1);
        if (q_cpu.size() != 0) begin
          check("rnd_cpu_sel", 32'(s_cpu), 32'(q_cpu[0].idx));
          check("rnd_cpu_len", 32'(l_cpu), 32'(q_cpu[0].len));
          if ($urandom_range(0, 1) == 1) begin
            p = q_cpu.pop_front();
            if ($urandom_range(0, 3) != 0) begin
              cpu_acc = 1'b1;
              q_fwd.push_back(p);
            end else begin
              cpu_rej = 1'b1;
            end
          end
        end
      end
      if (r_fwd) begin
        check("rnd_fwd_has_pkt", 32'(q_fwd.size() != 0), 1);
        if (q_fwd.size() != 0) begin
          check("rnd_fwd_sel", 32'(s_fwd), 32'(q_fwd[0].idx));
          check("rnd_fwd_len", 32'(l_fwd), 32'(q_fwd[0].len));
          if ($urandom_range(0, 2) == 0) begin
            p = q_fwd.pop_front();
            forwarder_done = 1'b1;
          end
        end
      end
      step();
      c++;
    end
    clr();
    check("rnd_drained", q_cpu.size() + q_fwd.size(), 0);
    repeat (4) step();
    check("rnd_idle_occ", 32'(occ),   1);
    check("rnd_idle_rs",  32'(r_snp), 1);
    check("rnd_idle_ss",  32'(s_snp), exp_sp);
    check("rnd_idle_rc",  32'(r_cpu), 0);
    check("rnd_idle_rf",  32'(r_fwd), 0);
    check("rnd_idle_err", 32'(r_err), 0);
  endtask

  logic [LW-1:0] lens3 [3];
  logic [LW-1:0] plen;

  initial begin
    // Reset values, then first edge after release.
    rst = 1'b0;
    repeat (2) step();
    check_reset_vals("rst_hold");
    rst = 1'b1;
    step();
    check("rel_rs",  32'(r_snp), 1);
    check("rel_ss",  32'(s_snp), 0);
    check("rel_rc",  32'(r_cpu), 0);
    check("rel_rf",  32'(r_fwd), 0);
    check("rel_occ", 32'(occ),   1);

    // One packet end to end with exact latencies.
    pulse_snoop(LW'(56));
    check("p0_pend_rc", 32'(r_cpu), 0);
    check("p0_pend_ss", 32'(s_snp), 1);
    check("p0_pend_rs", 32'(r_snp), 0);
    step();
    check("p0_rc",  32'(r_cpu), 1);
    check("p0_sc",  32'(s_cpu), 0);
    check("p0_lc",  32'(l_cpu), 56);
    check("p0_rs",  32'(r_snp), 1);
    check("p0_occ", 32'(occ),   2);
    pulse_cpu(1'b1, 1'b0);
    check("p0_acc_rf", 32'(r_fwd), 0);
    check("p0_acc_rc", 32'(r_cpu), 0);
    step();
    check("p0_rf", 32'(r_fwd), 1);
    check("p0_sf", 32'(s_fwd), 0);
    check("p0_lf", 32'(l_fwd), 56);
    pulse_fwd();
    check("p0_done_rf",  32'(r_fwd), 0);
    check("p0_done_occ", 32'(occ),   1);
    check("p0_done_err", 32'(r_err), 0);

    // Rejected buffer waits behind a long forward, then retires in one cycle.
    do_reset();
    lens3[0] = LW'(100);
    lens3[1] = LW'(200);
    lens3[2] = LW'(300);
    for (int k = 0; k < 3; k++) begin
      wait_rdy(0, "ord_wait_snp");
      check("ord_ss", 32'(s_snp), k);
      pulse_snoop(lens3[k]);
    end
    for (int k = 0; k < 3; k++) begin
      wait_rdy(1, "ord_wait_cpu");
      check("ord_sc", 32'(s_cpu), k);
      check("ord_lc", 32'(l_cpu), 32'(lens3[k]));
      pulse_cpu(k != 1, k == 1);
    end
    wait_rdy(2, "ord_wait_fwd");
    check("ord_sf0", 32'(s_fwd), 0);
    check("ord_lf0", 32'(l_fwd), 100);
    repeat (50) step();
    check("ord_hold_rf",  32'(r_fwd), 1);
    check("ord_hold_sf",  32'(s_fwd), 0);
    check("ord_hold_occ", 32'(occ),   4);
    check("ord_hold_ss",  32'(s_snp), 3);
    pulse_fwd();
    check("ord_f0_occ", 32'(occ),   3);
    check("ord_f0_rf",  32'(r_fwd), 0);
    step();
    check("ord_rej_occ", 32'(occ),   2);
    check("ord_rej_rf",  32'(r_fwd), 0);
    step();
    check("ord_sf2_rf", 32'(r_fwd), 1);
    check("ord_sf2_sf", 32'(s_fwd), 2);
    check("ord_sf2_lf", 32'(l_fwd), 300);
    pulse_fwd();
    check("ord_end_occ", 32'(occ),   1);
    check("ord_end_err", 32'(r_err), 0);

    // Full ring with the CPU stalled; one completed forward reopens buffer 0.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_rdy(0, "full_wait_snp");
      pulse_snoop(LW'(10 + k));
    end
    repeat (3) step();
    check("full_rs",  32'(r_snp), 0);
    check("full_ss",  32'(s_snp), 0);
    check("full_occ", 32'(occ),   4);
    wait_rdy(1, "full_wait_cpu");
    check("full_sc", 32'(s_cpu), 0);
    check("full_lc", 32'(l_cpu), 10);
    pulse_cpu(1'b1, 1'b0);
    wait_rdy(2, "full_wait_fwd");
    check("full_sf", 32'(s_fwd), 0);
    pulse_fwd();
    check("full_free_rs",  32'(r_snp), 0);
    check("full_free_occ", 32'(occ),   3);
    step();
    check("full_reopen_rs",  32'(r_snp), 1);
    check("full_reopen_ss",  32'(s_snp), 0);
    check("full_reopen_occ", 32'(occ),   4);

    // Protocol violations: stray forwarder_done, stray snooper_done, acc+rej.
    do_reset();
    step();
    pulse_fwd();
    check("vio_fd_err", 32'(r_err), 1);
    check("vio_fd_occ", 32'(occ),   1);
    check("vio_fd_rs",  32'(r_snp), 1);
    check("vio_fd_ss",  32'(s_snp), 0);
    check("vio_fd_rf",  32'(r_fwd), 0);
    do_reset();
    check("vio_rst_err", 32'(r_err), 0);
    step();
    pulse_snoop(LW'(77));
    pulse_snoop(LW'(88));
    check("vio_sd_err", 32'(r_err), 1);
    check("vio_sd_ss",  32'(s_snp), 1);
    check("vio_sd_rs",  32'(r_snp), 1);
    check("vio_sd_rc",  32'(r_cpu), 1);
    check("vio_sd_lc",  32'(l_cpu), 77);
    pulse_cpu(1'b1, 1'b1);
    check("vio_ar_rc", 32'(r_cpu), 0);
    check("vio_ar_rf", 32'(r_fwd), 0);
    step();
    check("vio_ar_occ", 32'(occ),   1);
    check("vio_ar_rf2", 32'(r_fwd), 0);
    check("vio_ar_err", 32'(r_err), 1);

    // Asynchronous reset while the forwarder owns a buffer.
    do_reset();
    wait_rdy(0, "mid_wait_snp");
    pulse_snoop(LW'(500));
    wait_rdy(1, "mid_wait_cpu");
    pulse_cpu(1'b1, 1'b0);
    wait_rdy(2, "mid_wait_fwd");
    #3;
    rst = 1'b0;
    #1;
    check_reset_vals("mid_rst");

    // Three-buffer ring: indices wrap 0,1,2,0,...; lengths travel with buffers.
    use3 = 1'b1;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      plen = LW'($urandom_range(1, 4095));
      wait_rdy(0, "nb3_wait_snp");
      check("nb3_ss", 32'(s_snp), k % 3);
      pulse_snoop(plen);
      wait_rdy(1, "nb3_wait_cpu");
      check("nb3_sc", 32'(s_cpu), k % 3);
      check("nb3_lc", 32'(l_cpu), 32'(plen));
      pulse_cpu(1'b1, 1'b0);
      wait_rdy(2, "nb3_wait_fwd");
      check("nb3_sf", 32'(s_fwd), k % 3);
      check("nb3_lf", 32'(l_fwd), 32'(plen));
      pulse_fwd();
    end

    random_run(4, 1500, 1'b0);
    random_run(3, 1500, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
